datapath_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the single-cycle LegV8 datapath: register file, ALU and data RAM.
- Stage EX: register read, B-select, ALU, status flags.
- Stage WB: RAM read/write and register write-back.
- Adds valid/ready issue handshake, load-use stall, WB→EX forwarding, XZR (top register reads zero) and parametrised width/depth.

---
 rtl/datapath_pipe.sv | 196 +++++++++++++++++++
 tb/tb_datapath_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage pipelined LegV8-style datapath (register file, ALU, data RAM).
//   EX : register read (XZR reads zero), B-select, ALU, status flags.
//   WB : RAM write for stores, synchronous RAM read for loads, register write-back.
// Optional feature macro: DATAPATH_FWD_EN
//   defined   -> WB-to-EX forwarding of the write-back value.
//   undefined -> no forwarding; EX stalls (in_ready=0) while a matching WB write is in flight.
// Ports:
//   clock, R (async active-low reset)
//   in_valid/in_ready       issue handshake; op accepted on rising edge when both high
//   k, DA, SA, SB, FS       constant operand, dest/source registers, ALU function
//   dataMux, regW, ramW, Bsel  write-back select, register/RAM write enables, B-operand select
//   data, wb_valid, wb_da   write-back value / strobe / destination of the retiring op
//   status                  {V,C,N,Z} of the last accepted op
module datapath_pipe #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned REG_CNT = 32,
  parameter int unsigned RAM_AW  = 8
) (
  input  logic                       clock,
  input  logic                       R,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          k,
  input  logic [$clog2(REG_CNT)-1:0] DA,
  input  logic [$clog2(REG_CNT)-1:0] SA,
  input  logic [$clog2(REG_CNT)-1:0] SB,
  input  logic [4:0]                 FS,
  input  logic                       dataMux,
  input  logic                       regW,
  input  logic                       ramW,
  input  logic                       Bsel,
  output logic [DATA_W-1:0]          data,
  output logic [3:0]                 status,
  output logic                       wb_valid,
  output logic [$clog2(REG_CNT)-1:0] wb_da
);

  localparam int unsigned RW       = $clog2(REG_CNT);
  localparam logic [RW-1:0] Xzr    = RW'(REG_CNT - 1);
  localparam int unsigned RamDepth = 1 << RAM_AW;

  typedef enum logic [1:0] {WbIdle, WbAlu, WbLoad1, WbLoad2} wb_state_e;

  wb_state_e         state_q, state_d;
  logic [DATA_W-1:0] rf_q [REG_CNT];
  logic [DATA_W-1:0] rf_d [REG_CNT];
  logic [DATA_W-1:0] mem  [RamDepth];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] stb_q, stb_d;
  logic [RW-1:0]     da_q, da_d;
  logic              regw_q, regw_d;
  logic              ramw_q, ramw_d;
  logic [3:0]        status_q, status_d;

  logic              accept, retiring, wb_wr, hazard;
  logic [DATA_W-1:0] wb_val;
  logic [DATA_W-1:0] a_rd, b_rd, b_in, a_op, b_op, res;
  logic [DATA_W:0]   sum_ext;
  logic              c_f, v_f;
  logic [RAM_AW-1:0] ram_addr;

  // ---------------------------------------------------------------------------
  // Write-back side
  // ---------------------------------------------------------------------------
  assign retiring = (state_q == WbAlu) || (state_q == WbLoad2);
  assign wb_val   = (state_q == WbLoad2) ? rdata_q : alu_q;
  assign wb_wr    = retiring && regw_q && (da_q != Xzr);
  // Upper ALU bits above RAM_AW are ignored, so addresses wrap.
  assign ram_addr = alu_q[RAM_AW-1:0];

  // ---------------------------------------------------------------------------
  // Register read with XZR and optional forwarding
  // ---------------------------------------------------------------------------
  always_comb begin
    a_rd = (SA == Xzr) ? '0 : rf_q[SA];
    b_rd = (SB == Xzr) ? '0 : rf_q[SB];
`ifdef DATAPATH_FWD_EN
    // wb_wr already excludes XZR, so an XZR source keeps reading zero.
    if (wb_wr && (da_q == SA)) a_rd = wb_val;
    if (wb_wr && (da_q == SB)) b_rd = wb_val;
`endif
  end

`ifdef DATAPATH_FWD_EN
  assign hazard = 1'b0;
`else
  // Without forwarding, hold EX until the pending write has landed in the register file;
  // the op is then read from the updated array in the following cycle.
  assign hazard = (state_q != WbIdle) && regw_q && (da_q != Xzr) &&
                  ((da_q == SA) || (da_q == SB));
`endif

  // Loads own the RAM read port in WbLoad1, which costs one issue slot.
  assign in_ready = (state_q != WbLoad1) && !hazard;
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  always_comb begin
    b_in    = Bsel ? b_rd : k;
    a_op    = FS[1] ? ~a_rd : a_rd;
    b_op    = FS[0] ? ~b_in : b_in;
    sum_ext = {1'b0, a_op} + {1'b0, b_op} + {{DATA_W{1'b0}}, FS[0]};
    res     = a_op;
    c_f     = 1'b0;
    v_f     = 1'b0;
    unique case (FS[4:2])
      3'b000: res = a_op & b_op;
      3'b001: res = a_op | b_op;
      3'b010: begin
        res = sum_ext[DATA_W-1:0];
        c_f = sum_ext[DATA_W];
        v_f = (a_op[DATA_W-1] == b_op[DATA_W-1]) && (res[DATA_W-1] != a_op[DATA_W-1]);
      end
      3'b011: res = a_op ^ b_op;
      3'b100: res = a_op << b_op[5:0];
      3'b101: res = a_op >> b_op[5:0];
      3'b110: res = b_op;
      default: res = a_op;
    endcase
  end

  // ---------------------------------------------------------------------------
  // WB FSM and EX/WB pipeline register
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = WbIdle;
    alu_d    = alu_q;
    stb_d    = stb_q;
    da_d     = da_q;
    regw_d   = regw_q;
    ramw_d   = ramw_q;
    status_d = status_q;
    if (state_q == WbLoad1) begin
      state_d = WbLoad2;
    end else if (accept) begin
      state_d  = dataMux ? WbLoad1 : WbAlu;
      alu_d    = res;
      stb_d    = b_rd;
      da_d     = DA;
      regw_d   = regW;
      ramw_d   = ramW;
      status_d = {v_f, c_f, res[DATA_W-1], (res == '0)};
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (state_q == WbLoad1) rdata_d = mem[ram_addr];
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_wr) rf_d[da_q] = wb_val;
  end

  always_ff @(posedge clock or negedge R) begin
    if (!R) begin
      state_q  <= WbIdle;
      rdata_q  <= '0;
      alu_q    <= '0;
      stb_q    <= '0;
      da_q     <= '0;
      regw_q   <= 1'b0;
      ramw_q   <= 1'b0;
      status_q <= '0;
      for (int unsigned i = 0; i < REG_CNT; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      alu_q    <= alu_d;
      stb_q    <= stb_d;
      da_q     <= da_d;
      regw_q   <= regw_d;
      ramw_q   <= ramw_d;
      status_q <= status_d;
      rf_q     <= rf_d;
    end
  end

  // RAM contents are not reset. Stores write in the first WB cycle of their op.
  always_ff @(posedge clock) begin
    if (ramw_q && ((state_q == WbAlu) || (state_q == WbLoad1))) mem[ram_addr] <= stb_q;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign data     = retiring ? wb_val : '0;
  assign wb_valid = retiring;
  assign wb_da    = retiring ? da_q : '0;
  assign status   = status_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// tb_datapath_pipe: self-checking bench for datapath_pipe (default parameters).
// An architectural model applies each accepted op in order; the expected write-back
// stream and status are compared against the DUT, plus directed scenario checks.
module tb_datapath_pipe;

`ifdef DATAPATH_FWD_EN
  localparam int ExpB2bStall = 0;
  localparam int ExpLuStall  = 1;
`else
  localparam int ExpB2bStall = 1;
  localparam int ExpLuStall  = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] k = '0;
  logic [4:0]  da = '0, sa = '0, sb = '0, fs = '0;
  logic        data_mux = 1'b0, reg_w = 1'b0, ram_w = 1'b0, b_sel = 1'b0;
  logic [63:0] data;
  logic [3:0]  status;
  logic        wb_valid;
  logic [4:0]  wb_da;

  datapath_pipe dut (
    .clock   (clk),
    .R       (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .k       (k),
    .DA      (da),
    .SA      (sa),
    .SB      (sb),
    .FS      (fs),
    .dataMux (data_mux),
    .regW    (reg_w),
    .ramW    (ram_w),
    .Bsel    (b_sel),
    .data    (data),
    .status  (status),
    .wb_valid(wb_valid),
    .wb_da   (wb_da)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] k;
    logic [4:0]  fs, da, sa, sb;
    logic        bs, dm, rw, mw;
  } op_t;

  typedef struct packed {
    logic [4:0]  da;
    logic [63:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mreg [32];
  logic [63:0] mem_m [256];
  bit          mem_ok [256];
  logic [7:0]  wr_list[$];
  logic [3:0]  exp_status = '0;
  bit          mon_en = 1'b0;
  logic [63:0] seen_val [32];
  bit          seen_ok [32];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] rd(input logic [4:0] r);
    return (r == 5'd31) ? 64'd0 : mreg[r];
  endfunction

  function automatic void ref_alu(input logic [4:0] f, input logic [63:0] a0, input logic [63:0] b0,
                                  output logic [63:0] r, output logic [3:0] st);
    logic [63:0]        a, b;
    logic [64:0]        u;
    logic signed [65:0] s;
    logic               c, v;
    a = f[1] ? ~a0 : a0;
    b = f[0] ? ~b0 : b0;
    c = 1'b0;
    v = 1'b0;
    case (f[4:2])
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        u = 65'(a) + 65'(b) + 65'(f[0]);
        s = 66'($signed(a)) + 66'($signed(b)) + 66'(f[0]);
        r = u[63:0];
        c = u[64];
        v = (s[64] != s[63]);  // true signed sum does not fit in 64 bits
      end
      3'd3: r = a ^ b;
      3'd4: r = a << b[5:0];
      3'd5: r = a >> b[5:0];
      3'd6: r = b;
      default: r = a;
    endcase
    st = {v, c, r[63], (r == 64'd0)};
  endfunction

  function automatic logic [63:0] peek_alu(input op_t op);
    logic [63:0] r;
    logic [3:0]  st;
    ref_alu(op.fs, rd(op.sa), op.bs ? rd(op.sb) : op.k, r, st);
    return r;
  endfunction

  task automatic model_accept(input op_t op);
    logic [63:0] a, breg, r, wv;
    logic [3:0]  st;
    logic [7:0]  addr;
    a    = rd(op.sa);
    breg = rd(op.sb);
    ref_alu(op.fs, a, op.bs ? breg : op.k, r, st);
    exp_status = st;
    addr = r[7:0];
    if (op.mw) begin
      if (!mem_ok[addr]) wr_list.push_back(addr);
      mem_m[addr]  = breg;
      mem_ok[addr] = 1'b1;
    end
    wv = op.dm ? mem_m[addr] : r;
    exp_q.push_back({op.da, wv});
    if (op.rw && op.da != 5'd31) mreg[op.da] = wv;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    for (int i = 0; i < 256; i++) mem_ok[i] = 1'b0;
    wr_list.delete();
    exp_q.delete();
    exp_status = '0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check_eq("status", status, exp_status);
      if (wb_valid) begin
        seen_val[wb_da] = data;
        seen_ok[wb_da]  = 1'b1;
        if (exp_q.size() == 0) begin
          check_eq("spurious_retire", wb_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("wb_data", data, e.val);
          check_eq("wb_da", wb_da, e.da);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic op_t mk(input logic [4:0] f, input logic [4:0] d, input logic [4:0] a,
                             input logic [4:0] b, input logic bs, input logic dm, input logic rw,
                             input logic mw, input logic [63:0] kk);
    op_t o;
    o.fs = f; o.da = d; o.sa = a; o.sb = b;
    o.bs = bs; o.dm = dm; o.rw = rw; o.mw = mw; o.k = kk;
    return o;
  endfunction

  // Presents op until accepted; stalls = cycles spent with in_ready low.
  task automatic issue(input op_t op, output int stalls);
    logic acc;
    k = op.k; fs = op.fs; da = op.da; sa = op.sa; sb = op.sb;
    b_sel = op.bs; data_mux = op.dm; reg_w = op.rw; ram_w = op.mw;
    in_valid = 1'b1;
    stalls = 0;
    acc = 1'b0;
    while (!acc && stalls < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) stalls++;
    end
    if (acc) model_accept(op);
    else check_eq("issue_timeout", in_ready, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_data"}, data, 0);
    check_eq({tag, "_status"}, status, 0);
    check_eq({tag, "_wb_valid"}, wb_valid, 0);
    check_eq({tag, "_wb_da"}, wb_da, 0);
    check_eq({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   st;
    op_t  op;
    logic [63:0] ad;
    model_reset();
    for (int i = 0; i < 32; i++) seen_ok[i] = 1'b0;

    #3;
    check_reset_state("rst0");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // Back-to-back ALU: X1 = 5, X2 = X1 + X1
    issue(mk(5'b11000, 5'd1, 5'd31, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 64'd5), st);
    issue(mk(5'b01000, 5'd2, 5'd1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0), st);
    check_eq("b2b_stall", st, ExpB2bStall);
    idle(3);
    check_eq("x2_data", seen_val[2], 10);

    // Subtract with Z and C set
    issue(mk(5'b11000, 5'd3, 5'd31, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 64'd5), st);
    issue(mk(5'b11000, 5'd4, 5'd31, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 64'd5), st);
    issue(mk(5'b01001, 5'd5, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0), st);
    check_eq("sub_status", status, 4'b0101);
    idle(3);
    check_eq("x5_data", seen_val[5], 0);

    // Store X1 -> 0x10, load X6, X7 = X6 + 1
    issue(mk(5'b01000, 5'd0, 5'd31, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h10), st);
    issue(mk(5'b01000, 5'd6, 5'd31, 5'd31, 1'b0, 1'b1, 1'b1, 1'b0, 64'h10), st);
    check_eq("load_issue_stall", st, 0);
    issue(mk(5'b01000, 5'd7, 5'd6, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 64'd1), st);
    check_eq("load_use_stall", st, ExpLuStall);
    idle(4);
    check_eq("x6_data", seen_val[6], 5);
    check_eq("x7_data", seen_val[7], 6);

    // XZR: write is discarded, reads stay zero
    issue(mk(5'b11000, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 64'hFF), st);
    issue(mk(5'b01000, 5'd8, 5'd31, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 64'd3), st);
    idle(3);
    check_eq("x31_wb_data", seen_val[31], 64'hFF);
    check_eq("x8_data", seen_val[8], 3);

    // Address wrap: store X2 at 0x105, load from 0x05
    issue(mk(5'b01000, 5'd0, 5'd31, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 64'h105), st);
    issue(mk(5'b01000, 5'd9, 5'd31, 5'd31, 1'b0, 1'b1, 1'b1, 1'b0, 64'h5), st);
    idle(4);
    check_eq("x9_wrap", seen_val[9], 10);

    // Reset in the middle of a load
    seen_ok[11] = 1'b0;
    issue(mk(5'b01000, 5'd11, 5'd31, 5'd31, 1'b0, 1'b1, 1'b1, 1'b0, 64'h10), st);
    in_valid = 1'b0;
    mon_en   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_mid");
    model_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(3);
    check_eq("aborted_load", seen_ok[11], 0);
    issue(mk(5'b01000, 5'd10, 5'd6, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0), st);
    idle(3);
    check_eq("x10_after_reset", seen_val[10], 0);

    // Seed registers, then random traffic
    for (int r = 0; r < 31; r++) begin
      issue(mk(5'b11000, 5'(r), 5'd31, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0,
               {$urandom, $urandom}), st);
    end
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
      op.fs = 5'($urandom_range(0, 31));
      op.da = 5'($urandom_range(0, 31));
      op.sa = 5'($urandom_range(0, 31));
      op.sb = 5'($urandom_range(0, 31));
      op.bs = 1'($urandom_range(0, 1));
      op.rw = ($urandom_range(0, 3) != 0);
      op.mw = 1'b0;
      op.dm = 1'b0;
      op.k  = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 300));
      case ($urandom_range(0, 5))
        0: begin  // store to a small address window
          op.mw = 1'b1;
          op.fs = 5'b01000;
          op.sa = 5'd31;
          op.bs = 1'b0;
          op.k  = 64'($urandom_range(0, 15)) | (64'($urandom_range(0, 3)) << 8);
        end
        1: begin  // load from an address written earlier
          if (wr_list.size() != 0) begin
            op.dm = 1'b1;
            op.fs = 5'b01000;
            op.sa = 5'd31;
            op.bs = 1'b0;
            op.k  = 64'(wr_list[$urandom_range(0, wr_list.size() - 1)]);
          end
        end
        default: ;
      endcase
      if (op.dm) begin
        ad = peek_alu(op);
        if (!mem_ok[ad[7:0]]) op.dm = 1'b0;
      end
      issue(op, st);
    end
    idle(6);
    check_eq("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
